conv_window_addr_gen: RTL and testbench

- Upstream address generator for the input-router row group.
- Walks every output pixel of a KxK convolution over a square input feature map in raster order.
- For each pixel, emits one window of ADDR_LENGTH SRAM word addresses plus the destination row-router id. The row group writes the window into that router's address FIFO.
- One window per cycle under a valid/ready handshake.

---
 rtl/conv_window_addr_gen_if.sv | 24 ++
 rtl/conv_window_addr_gen.sv | 158 +++++++++++++++
 tb/tb_conv_window_addr_gen.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_addr_gen_if.sv
// ---------------------------------------------------------------------------
// conv_window_addr_gen_if
//   Window stream from the convolution address generator to the input-router
//   row group. One transfer moves a full KxK window of SRAM word addresses
//   together with the row-router id that should receive it.
//
//   o_addr    window addresses, element kr*K+kc = top-left + kr*W + kc
//   o_valid   window valid
//   o_row_id  destination row-router index
//   i_ready   downstream accepts the current window
// ---------------------------------------------------------------------------
interface conv_window_addr_gen_if #(
  parameter int ADDR_LENGTH  = 9,
  parameter int ADDR_WIDTH   = 8,
  parameter int ROUTER_COUNT = 4
);
  logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0] o_addr;
  logic                                   o_valid;
  logic [ROUTER_COUNT-1:0]                o_row_id;
  logic                                   i_ready;

  modport master (output o_addr, output o_valid, output o_row_id, input i_ready);
  modport slave  (input o_addr, input o_valid, input o_row_id, output i_ready);
endinterface

// File: rtl/conv_window_addr_gen.sv
// ---------------------------------------------------------------------------
// conv_window_addr_gen
//   Walks every output pixel of a KxK convolution over a square input map in
//   raster order and emits one window of SRAM addresses per pixel, tagged
//   with a round-robin row-router id. One window per cycle at full rate.
//
//   i_clk, i_nrst     clock, asynchronous active-low reset
//   i_reg_clear       synchronous clear back to the reset state (aborts a run)
//   i_start           start pulse, sampled only while idle
//   i_base_addr       address of input pixel (0,0)
//   i_i_size          input map side W
//   i_o_size          output map side O (0 = empty run, just pulses o_done)
//   i_stride          stride S, 0 behaves as 1
//   win_if            window stream (master side)
//   o_busy            high while generating and during the done cycle
//   o_done            one-cycle pulse after the last window is accepted
// ---------------------------------------------------------------------------
module conv_window_addr_gen #(
  parameter int ROUTER_COUNT = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int ADDR_LENGTH  = 9
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_reg_clear,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_i_size,
  input  logic [ADDR_WIDTH-1:0] i_o_size,
  input  logic [1:0]            i_stride,
  conv_window_addr_gen_if.master win_if,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;
  typedef logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0] win_t;

  // Run configuration latched at start plus the raster-walk position.
  // row_off tracks orow*S*W and col_off tracks ocol*S, so stepping to the
  // next pixel needs only additions.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] w;
    logic [ADDR_WIDTH-1:0] o;
    logic [ADDR_WIDTH-1:0] s;
    logic [ADDR_WIDTH-1:0] sw;
    logic [ADDR_WIDTH-1:0] orow;
    logic [ADDR_WIDTH-1:0] ocol;
    logic [ADDR_WIDTH-1:0] row_off;
    logic [ADDR_WIDTH-1:0] col_off;
  } ctx_t;

  state_t                  r_state, w_state_nxt;
  ctx_t                    r_ctx;
  win_t                    r_addr, w_addr_nxt;
  logic [ROUTER_COUNT-1:0] r_row_id;

  logic                    w_start, w_load, w_hs, w_last_col, w_last_pix;
  logic [ADDR_WIDTH-1:0]   w_s_in, w_row_off_nxt, w_col_off_nxt;
  logic [ADDR_WIDTH-1:0]   w_tl, w_win_w, w_rb;

  assign w_s_in     = (i_stride == 2'd0) ? ADDR_WIDTH'(1) : ADDR_WIDTH'(i_stride);
  assign w_start    = (r_state == S_IDLE) && i_start;
  assign w_load     = w_start && (i_o_size != '0);
  assign w_hs       = (r_state == S_GEN) && win_if.i_ready;
  assign w_last_col = (r_ctx.ocol == r_ctx.o - 1'b1);
  assign w_last_pix = w_last_col && (r_ctx.orow == r_ctx.o - 1'b1);

  // NOTE: every combinational output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = (i_o_size == '0) ? S_DONE : S_GEN;
      S_GEN:   if (win_if.i_ready && w_last_pix) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next window. At start the first window comes straight from the inputs
  // (the config registers are not loaded yet); afterwards it is the pixel
  // following the current one.
  // NOTE: w_rb is a running sum reused across loop iterations, so it needs
  // blocking assignments; registered state below uses non-blocking only.
  always_comb begin
    w_row_off_nxt = w_last_col ? r_ctx.row_off + r_ctx.sw : r_ctx.row_off;
    w_col_off_nxt = w_last_col ? '0 : r_ctx.col_off + r_ctx.s;
    if (w_load) begin
      w_tl    = i_base_addr;
      w_win_w = i_i_size;
    end else begin
      w_tl    = r_ctx.base + w_row_off_nxt + w_col_off_nxt;
      w_win_w = r_ctx.w;
    end
    w_rb       = w_tl;
    w_addr_nxt = '0;
    for (int kr = 0; kr < KERNEL_SIZE; kr++) begin
      for (int kc = 0; kc < KERNEL_SIZE; kc++) begin
        w_addr_nxt[kr*KERNEL_SIZE+kc] = w_rb + ADDR_WIDTH'(kc);
      end
      w_rb = w_rb + w_win_w;
    end
  end

  // NOTE: the window register is small flop storage driving outputs that
  // must read zero after reset, so it is reset like any other state.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state  <= S_IDLE;
      r_ctx    <= '0;
      r_addr   <= '0;
      r_row_id <= '0;
    end else if (i_reg_clear) begin
      r_state  <= S_IDLE;
      r_ctx    <= '0;
      r_addr   <= '0;
      r_row_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_ctx.base    <= i_base_addr;
        r_ctx.w       <= i_i_size;
        r_ctx.o       <= i_o_size;
        r_ctx.s       <= w_s_in;
        r_ctx.sw      <= w_s_in * i_i_size;
        r_ctx.orow    <= '0;
        r_ctx.ocol    <= '0;
        r_ctx.row_off <= '0;
        r_ctx.col_off <= '0;
        r_row_id      <= '0;
        if (w_load) r_addr <= w_addr_nxt;
      end else if (w_hs) begin
        // On the last pixel this loads a don't-care window; o_valid drops.
        r_addr        <= w_addr_nxt;
        r_ctx.row_off <= w_row_off_nxt;
        r_ctx.col_off <= w_col_off_nxt;
        if (w_last_col) begin
          r_ctx.ocol <= '0;
          r_ctx.orow <= r_ctx.orow + 1'b1;
        end else begin
          r_ctx.ocol <= r_ctx.ocol + 1'b1;
        end
        // Router id keeps counting across output rows.
        r_row_id <= (r_row_id == ROUTER_COUNT'(ROUTER_COUNT - 1)) ? '0 : r_row_id + 1'b1;
      end
    end
  end

  assign win_if.o_addr   = r_addr;
  assign win_if.o_valid  = (r_state == S_GEN);
  assign win_if.o_row_id = r_row_id;
  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = (r_state == S_DONE);

endmodule

// File: tb/tb_conv_window_addr_gen.sv
module tb_conv_window_addr_gen;
  localparam int RC = 4;
  localparam int AW = 8;
  localparam int K  = 3;
  localparam int AL = 9;

  typedef logic [0:AL-1][AW-1:0] win_t;
  typedef enum {M_IDLE, M_GEN, M_DONE} mphase_t;

  logic          i_clk = 1'b0;
  logic          i_nrst = 1'b0;
  logic          i_reg_clear = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [AW-1:0] i_i_size = '0;
  logic [AW-1:0] i_o_size = '0;
  logic [1:0]    i_stride = '0;
  logic          o_busy, o_done;

  conv_window_addr_gen_if #(.ADDR_LENGTH(AL), .ADDR_WIDTH(AW), .ROUTER_COUNT(RC)) bus ();

  conv_window_addr_gen #(
    .ROUTER_COUNT(RC), .ADDR_WIDTH(AW), .KERNEL_SIZE(K), .ADDR_LENGTH(AL)
  ) dut (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_reg_clear(i_reg_clear),
    .i_start    (i_start),
    .i_base_addr(i_base_addr),
    .i_i_size   (i_i_size),
    .i_o_size   (i_o_size),
    .i_stride   (i_stride),
    .win_if     (bus),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the list of windows a run must produce, how many have
  // been accepted, and which phase of the run the outputs should show.
  mphase_t m_phase  = M_IDLE;
  win_t    m_q[$];
  int      m_ptr    = 0;
  bit      m_zeroed = 1'b1;

  int ready_mode = 0;  // 0: always ready, 1: random, 2: stall 3 cycles on pixel 2
  int stall_cnt  = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic win_t win_of(int base, int w, int s, int orow, int ocol);
    win_t r;
    int   tl;
    tl = base + orow * s * w + ocol * s;
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++)
        r[kr*K+kc] = AW'(tl + kr * w + kc);
    return r;
  endfunction

  task automatic build_run(int base, int w, int o, int s_raw);
    int s;
    s = (s_raw == 0) ? 1 : s_raw;
    m_q.delete();
    for (int r = 0; r < o; r++)
      for (int c = 0; c < o; c++)
        m_q.push_back(win_of(base, w, s, r, c));
  endtask

  // Compare process: check outputs against the model mid-cycle, then advance
  // the model using the inputs the next rising edge will sample.
  always @(negedge i_clk) begin
    if (!i_nrst) begin
      m_phase  = M_IDLE;
      m_zeroed = 1'b1;
      m_ptr    = 0;
    end
    check("valid", bus.o_valid, m_phase == M_GEN);
    check("busy",  o_busy,      m_phase != M_IDLE);
    check("done",  o_done,      m_phase == M_DONE);
    if (m_phase == M_GEN) begin
      check("addr",   bus.o_addr,   m_q[m_ptr]);
      check("row_id", bus.o_row_id, m_ptr % RC);
    end else if (m_zeroed) begin
      check("addr_zero",   bus.o_addr,   0);
      check("row_id_zero", bus.o_row_id, 0);
    end
    if (i_nrst) begin
      if (i_reg_clear) begin
        m_phase  = M_IDLE;
        m_zeroed = 1'b1;
      end else begin
        case (m_phase)
          M_IDLE: if (i_start) begin
            build_run(int'(i_base_addr), int'(i_i_size), int'(i_o_size), int'(i_stride));
            m_ptr    = 0;
            m_zeroed = 1'b0;
            m_phase  = (m_q.size() == 0) ? M_DONE : M_GEN;
          end
          M_GEN: if (bus.i_ready) begin
            m_ptr++;
            if (m_ptr == m_q.size()) m_phase = M_DONE;
          end
          default: m_phase = M_IDLE;
        endcase
      end
    end
  end

  // Ready driver, changes just after each rising edge.
  initial bus.i_ready = 1'b1;
  always @(posedge i_clk) begin
    #1;
    case (ready_mode)
      1: bus.i_ready = ($urandom_range(0, 3) != 0);
      2: if (m_phase == M_GEN && m_ptr == 2 && stall_cnt < 3) begin
           bus.i_ready = 1'b0;
           stall_cnt++;
         end else begin
           bus.i_ready = 1'b1;
         end
      default: bus.i_ready = 1'b1;
    endcase
  end

  // Returns one step after the edge that samples i_start; config inputs are
  // then scrambled to show they are ignored for the rest of the run.
  task automatic start_run(int base, int w, int o, int s);
    @(posedge i_clk); #1;
    i_base_addr = AW'(base);
    i_i_size    = AW'(w);
    i_o_size    = AW'(o);
    i_stride    = 2'(s);
    i_start     = 1'b1;
    @(posedge i_clk); #1;
    i_start     = 1'b0;
    i_base_addr = AW'($urandom);
    i_i_size    = AW'($urandom);
    i_o_size    = AW'($urandom);
    i_stride    = 2'($urandom);
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (m_phase != M_IDLE && n < budget) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("run_timeout", m_phase, M_IDLE);
  endtask

  // Cycles from the first window cycle until o_done is seen.
  task automatic done_latency(output int n);
    n = 0;
    while (!o_done && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
  endtask

  task automatic wait_pixel(int p);
    int n = 0;
    while (m_ptr != p && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("reach_pixel", m_ptr, p);
  endtask

  initial begin
    win_t lit;
    int   lat;

    // Hand-computed windows pin the model's address rule.
    lit = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    check("pin_p0", win_of(0, 5, 1, 0, 0), lit);
    lit = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    check("pin_p4", win_of(0, 5, 1, 1, 1), lit);
    lit = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    check("pin_p8", win_of(0, 5, 1, 2, 2), lit);
    lit = '{18, 19, 20, 25, 26, 27, 32, 33, 34};
    check("pin_s2", win_of(0, 7, 2, 1, 2), lit);
    lit = '{250, 251, 252, 255, 0, 1, 4, 5, 6};
    check("pin_wrap", win_of(250, 5, 1, 0, 0), lit);
    lit = '{2, 3, 4, 7, 8, 9, 12, 13, 14};
    check("pin_p2", win_of(0, 5, 1, 0, 2), lit);

    repeat (3) @(posedge i_clk);
    #1 i_nrst = 1'b1;

    // Basic run at full rate: done appears after 9 accepted windows.
    ready_mode = 0;
    start_run(0, 5, 3, 1);
    done_latency(lat);
    check("done_lat_full", lat, 9);
    wait_idle(100);

    start_run(0, 7, 3, 2);
    wait_idle(100);

    // Three stall cycles on pixel 2 push done out by exactly three cycles.
    ready_mode = 2;
    stall_cnt  = 0;
    start_run(0, 5, 3, 1);
    done_latency(lat);
    check("done_lat_stall", lat, 12);
    wait_idle(100);
    ready_mode = 0;

    start_run(250, 5, 1, 1);
    wait_idle(100);

    // Empty run: no windows, done straight away.
    start_run(0, 5, 0, 1);
    check("o0_done", o_done, 1'b1);
    wait_idle(100);

    // Start during generation is ignored.
    start_run(0, 5, 3, 1);
    repeat (2) @(posedge i_clk);
    #1 i_start = 1'b1;
    i_o_size   = 8'd1;
    @(posedge i_clk); #1 i_start = 1'b0;
    wait_idle(100);

    // Stride 0 behaves as stride 1.
    ready_mode = 1;
    start_run(3, 9, 3, 0);
    wait_idle(200);
    ready_mode = 0;

    // Synchronous clear during pixel 3, then a fresh run.
    start_run(0, 5, 3, 1);
    wait_pixel(3);
    i_reg_clear = 1'b1;
    @(posedge i_clk); #1 i_reg_clear = 1'b0;
    check("clear_idle", o_busy, 1'b0);
    start_run(0, 5, 3, 1);
    wait_idle(100);

    // Asynchronous reset during pixel 3, then a fresh run.
    start_run(0, 5, 3, 1);
    wait_pixel(3);
    i_nrst = 1'b0;
    @(posedge i_clk); #1 i_nrst = 1'b1;
    check("rst_idle", o_busy, 1'b0);
    start_run(0, 5, 3, 1);
    wait_idle(100);

    // Random configurations under random backpressure.
    ready_mode = 1;
    for (int t = 0; t < 25; t++) begin
      int s_raw, s, o, w, base;
      s_raw = $urandom_range(0, 3);
      s     = (s_raw == 0) ? 1 : s_raw;
      o     = $urandom_range(0, 5);
      w     = ((o == 0) ? K : (o - 1) * s + K) + $urandom_range(0, 6);
      base  = $urandom_range(0, 255);
      start_run(base, w, o, s_raw);
      wait_idle(400);
    end

    repeat (3) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
